// File: rtl/video_timing_ctrl_pkg.sv
// Shared constants and types for the video timing controller.
// Holds the 720p default timing, derived totals, FSM state type and the
// pipeline-stage control bundle. Imported by video_timing_ctrl and hv_counter.
package video_timing_pkg;

  localparam int CNT_W = 12;   // h/v counter width
  localparam int POS_W = 11;   // pixel coordinate width
  localparam int RGB_W = 24;   // RGB888

  // 1280x720p60 defaults
  localparam int DEF_H_SYNC  = 40;
  localparam int DEF_H_BACK  = 220;
  localparam int DEF_H_DISP  = 1280;
  localparam int DEF_H_FRONT = 110;
  localparam int DEF_V_SYNC  = 5;
  localparam int DEF_V_BACK  = 20;
  localparam int DEF_V_DISP  = 720;
  localparam int DEF_V_FRONT = 5;
  localparam bit DEF_SYNC_POL = 1'b1;

  localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_DISP + DEF_H_FRONT;
  localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_DISP + DEF_V_FRONT;

  // Cycles from the stage-0 decode to the transmitter-facing outputs.
  localparam int PIPE_DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // Control bits travelling down the pipeline alongside the counters' decode.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
  } ctrl_t;

  // Map a logical "sync active" flag onto the physical pin level.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/video_timing_ctrl_hv_counter.sv
// Horizontal/vertical raster counters.
// Ports: clk, reset_n (sync, active low), clear (hold at 0), run (advance),
// h_cnt/v_cnt (current position), frame_last (at H_TOTAL-1, V_TOTAL-1).
module hv_counter
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             run,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             frame_last
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic h_wrap;

  assign h_wrap     = (h_cnt == H_LAST);
  assign frame_last = h_wrap && (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (run) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// Frame sequencer for the DVI transmitter: H/V timing, pixel request with
// one-cycle lookahead, and registered RGB aligned with de/hsync/vsync.
// Ports: pclk, reset_n (sync, active low), enable/busy handshake, frame_start,
// pixel_req/xpos/ypos/data to the pixel source, video_* to the transmitter.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_DISP   = DEF_H_DISP,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_DISP   = DEF_V_DISP,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic             pclk,
  input  logic             reset_n,
  input  logic             enable,
  output logic             busy,
  output logic             frame_start,
  output logic             pixel_req,
  output logic [POS_W-1:0] pixel_xpos,
  output logic [POS_W-1:0] pixel_ypos,
  input  logic [RGB_W-1:0] pixel_data,
  output logic             video_de,
  output logic             video_hsync,
  output logic             video_vsync,
  output logic [RGB_W-1:0] video_rgb
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  // Region boundaries; *_END values are exclusive.
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_SYNC + V_BACK + V_DISP);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             frame_last;
  logic             cnt_run;
  logic             cnt_clear;
  logic             s0_act;
  ctrl_t            s0;
  ctrl_t            s1;
  ctrl_t            s2;
  logic [POS_W-1:0] s0_xpos;
  logic [POS_W-1:0] s0_ypos;

  hv_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_hv_counter (
    .clk        (pclk),
    .reset_n    (reset_n),
    .clear      (cnt_clear),
    .run        (cnt_run),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .frame_last (frame_last)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  // STOP only returns to IDLE on the last pixel of a frame, so a started
  // frame always completes; enable seen high in STOP resumes with no gap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = STOP;
      STOP: begin
        if (enable)          state_nxt = RUN;
        else if (frame_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Counters are held at (0,0) in IDLE so the first RUN cycle is the frame origin.
  always_comb begin
    busy      = (state != IDLE);
    s0_act    = (state != IDLE);
    cnt_run   = (state != IDLE);
    cnt_clear = (state == IDLE);
  end

  // ---------------- Stage 0 decode ----------------
  always_comb begin
    s0      = '0;
    s0_xpos = '0;
    s0_ypos = '0;
    if (s0_act) begin
      s0.hs = (h_cnt < H_SYNC_END);
      s0.vs = (v_cnt < V_SYNC_END);
      s0.de = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END) &&
              (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
      s0.fs = (h_cnt == '0) && (v_cnt == '0);
    end
    if (s0.de) begin
      s0_xpos = POS_W'(h_cnt - H_ACT_BEG);
      s0_ypos = POS_W'(v_cnt - V_ACT_BEG);
    end
  end

  // ---------------- Pipeline ----------------
  // Stage 1 issues the pixel request; the source answers during stage 2,
  // and stage 3 captures that answer together with the delayed controls.
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      pixel_req   <= 1'b0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      s1          <= '0;
      s2          <= '0;
      frame_start <= 1'b0;
      video_de    <= 1'b0;
      video_hsync <= ~SYNC_POL;
      video_vsync <= ~SYNC_POL;
      video_rgb   <= '0;
    end else begin
      pixel_req   <= s0.de;
      pixel_xpos  <= s0_xpos;
      pixel_ypos  <= s0_ypos;
      s1          <= s0;
      s2          <= s1;
      frame_start <= s2.fs;
      video_de    <= s2.de;
      video_hsync <= sync_level(s2.hs, SYNC_POL);
      video_vsync <= sync_level(s2.vs, SYNC_POL);
      video_rgb   <= s2.de ? pixel_data : '0;
    end
  end

endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
- Frame sequencer that drives the DVI transmitter's video inputs: video_de, video_hsync, video_vsync and 24-bit RGB.
- Runs H/V timing counters and issues a one-cycle-lookahead pixel request with coordinates to the pixel source (colorbar or framebuffer reader).
- Registers the returned RGB so data and control reach the encoders in the same cycle.
- Starts and stops only on frame boundaries, under an enable handshake.

Parameters:
- H_SYNC, 40, hsync width (pclk).
- H_BACK, 220, horizontal back porch.
- H_DISP, 1280, active pixels per line.
- H_FRONT, 110, horizontal front porch.
- V_SYNC, 5, vsync width (lines).
- V_BACK, 20, vertical back porch.
- V_DISP, 720, active lines.
- V_FRONT, 5, vertical front porch.
- SYNC_POL, 1, sync active level (1 = active high).
- Derived: H_TOTAL = sum of the H_* values (1650); V_TOTAL = sum of the V_* values (750). Counter widths are 12 bits.

Ports:
- pclk  in  1  pixel clock; only clock.
- reset_n  in  1  synchronous reset, active low.
- enable  in  1  request to run frames.
- busy  out  1  high whenever the state is not IDLE.
- frame_start  out  1  one-cycle pulse on the first video_vsync-active cycle of each frame.
- pixel_req  out  1  pixel data request.
- pixel_xpos  out  11  requested column 0..H_DISP-1; 0 when pixel_req is low.
- pixel_ypos  out  11  requested row 0..V_DISP-1; 0 when pixel_req is low.
- pixel_data  in  24  RGB888 from the source; valid in the cycle after pixel_req.
- video_de  out  1  to transmitter data enable.
- video_hsync  out  1  to transmitter.
- video_vsync  out  1  to transmitter.
- video_rgb  out  24  to transmitter video_din.

Behaviour:
- Reset (reset_n low at a pclk edge, any time, including mid-frame):
  - State goes to IDLE and both counters go to 0.
  - busy, frame_start, pixel_req, video_de = 0; pixel_xpos, pixel_ypos, video_rgb = 0.
  - video_hsync and video_vsync = ~SYNC_POL.
  - Pipeline stages are flushed; there is no partial line after release.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1 and wraps to 0.
  - Region order from count 0 is sync, back porch, active, front porch, for both H and V.
- Decode (stage 0):
  - hs = h_cnt < H_SYNC; vs = v_cnt < V_SYNC.
  - de = h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP-1] and v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP-1].
- Pipeline:
  - pixel_req, xpos = h_cnt-(H_SYNC+H_BACK) and ypos = v_cnt-(V_SYNC+V_BACK) are registered from stage-0 de (1 cycle).
  - hs, vs and de are delayed 3 cycles to video_hsync, video_vsync and video_de.
  - video_rgb registers pixel_data when the delayed de is high; otherwise it is 0.
  - Net timing: video_de rises exactly 2 cycles after pixel_req rises, and the pixel requested at cycle t appears on video_rgb at t+2.
- State machine:
  - IDLE: counters held at 0; stage 0 forced inactive.
  - IDLE -> RUN when enable is sampled high; the counters start at (0,0) on the next cycle.
  - RUN -> STOP when enable is sampled low.
  - STOP -> RUN when enable is sampled high again; no gap, the counters continue.
  - STOP -> IDLE when the counters are at (H_TOTAL-1, V_TOTAL-1); the last frame always completes.
  - If enable is high on that final cycle in STOP, the next state is RUN and the frame continues seamlessly.
  - Pipeline tail: after IDLE is entered, the 3-stage tail drains with inactive values.
- frame_start: derived from stage-0 (h=0, v=0) in RUN, delayed 3 cycles, so it aligns with video_vsync assertion.
- Sync polarity: outputs are driven at SYNC_POL when active and at ~SYNC_POL when inactive.

Decomposition:
- Package video_timing_pkg:
  - 720p default constants.
  - Derived H_TOTAL, V_TOTAL.
  - State enum {IDLE, RUN, STOP}.
  - Pipeline depth constant (3).
- Sub-module hv_counter: h/v counters with wrap, a clear input and a run input.
- The FSM, decode and pipeline live in the top of the block.

Test Plan:
- Small timing (H 2/2/4/2, V 1/1/3/1, H_TOTAL 10, V_TOTAL 6), enable held high:
  - video_hsync high 2 of every 10 cycles; video_vsync high for 10 cycles every 60.
  - video_de high 4 cycles on 3 lines per frame.
  - frame_start period 60.
- Pixel source returns data = {ypos, xpos} registered one cycle later:
  - video_rgb equals the expected coordinates on every video_de cycle.
  - video_de rises 2 cycles after pixel_req.
  - xpos runs 0..3; ypos runs 0..2.
- enable dropped mid-frame:
  - Frame completes, then IDLE; busy falls after the last cycle.
  - No further sync pulses; syncs held at ~SYNC_POL.
- enable re-asserted during STOP at line 4:
  - No interruption; frame_start period stays 60.
- reset_n pulsed low for 1 cycle mid-active-line:
  - All outputs reach reset values at the next edge.
  - After release with enable high, the first frame_start occurs 4 cycles later.
- SYNC_POL=0, 720p defaults:
  - hsync low for 40 of 1650 cycles.
  - 1280 de cycles per active line; 720 active lines per 750.
